wave_burst_sequencer: RTL and testbench
=======================================

// Module: wave_burst_sequencer
// PURPOSE
// - Plays a programmed list of triangle bursts on one DDS waveform generator.
// - Each segment is {freq, cycles, gap}. The sequencer drives the generator's freq/run/cycles inputs.
// - Completion of a burst is detected by the generator's active flag (ofs_kill) falling.
// - Sits between the host register block and the generator. It replaces direct host control of run.
// PARAMETERS
// - DEPTH     8   number of segment-table entries (power of 2, >=2)
// - ARM_CLKS  2   clocks after run rises during which gen_active is ignored (stale-flag mask)
// PORTS
// - clk              in   1   system clock, all logic posedge
// - rst_n            in   1   asynchronous active-low reset
// - wr_en            in   1   write one segment-table entry
// - wr_addr          in   $clog2(DEPTH)   entry index
// - wr_freq          in   32  segment frequency word (passed to generator unchanged)
// - wr_cycles        in   16  burst length in waveform cycles; 0 = endless
// - wr_gap           in   16  idle clocks after burst, run low
// - num_segments     in   $clog2(DEPTH)+1   segments to play, 0..DEPTH
// - start            in   1   1-clk pulse: begin at entry 0
// - stop             in   1   1-clk pulse: abort, run low, go idle
// - gen_active       in   1   generator ofs_kill (1 = burst still running)
// - gen_freq         out  32  registered freq to generator
// - gen_cycles       out  16  registered cycles to generator
// - gen_run          out  1   registered run to generator
// - busy             out  1   high in any state except IDLE
// - seg_idx          out  $clog2(DEPTH)   entry currently loaded
// - done             out  1   1-clk pulse when the list completes (not on stop)
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; table contents 0.
// - States and transitions:
//   - IDLE: start && num_segments!=0 -> LOAD with idx=0. A start with num_segments==0 is ignored.
//   - LOAD (1 clk): gen_freq/gen_cycles <= table[idx]; gen_run=0 -> RUN.
//     - run must be low for >=1 clk so the generator clears its phase and elapsed-cycle count.
//   - RUN: gen_run=1. The arm counter counts ARM_CLKS clocks. After that, gen_active==0 ends the burst.
//     - If gap!=0 -> GAP, else -> NEXT.
//     - cycles==0: the burst never ends by itself. Only stop exits.
//   - GAP: gen_run=0. Count gap clocks, then -> NEXT.
//   - NEXT (1 clk): if idx==num_segments-1 -> DONE, else idx++ and -> LOAD.
//   - DONE (1 clk): done=1 -> IDLE.
// - Latency:
//   - start at edge N -> gen_run=1 at edge N+2.
//   - Completion -> next gen_run rise takes gap+3 clks.
// - stop has priority over everything, including a simultaneous start.
//   - Next edge: state IDLE, gen_run=0, no done pulse.
//   - gen_freq/gen_cycles hold their values.
// - start while busy is ignored. Restart requires stop first or waiting for done.
// - Table writes are accepted in any state. The current segment is latched in LOAD, so a write affects only later loads.
// - Write and read of the same entry in the same clk: LOAD sees the old value.
// - num_segments is sampled each NEXT. Values >DEPTH are treated as DEPTH.
// - Counters are 16 bits and do not wrap: gap 16'hFFFF gives 65535 idle clks.
// - Reset mid-operation: gen_run drops asynchronously. Table is cleared.
// CONFIGURATION
// - WAVE_SEQ_LOOP_EN defined:
//   - Adds input loop (1 bit).
//   - At NEXT on the last entry with loop=1 -> idx=0 -> LOAD. done pulses once per pass.
//   - Only stop ends playback.
// - Not defined: port absent; list plays once -> DONE -> IDLE.
// STRUCTURE
// - wave_pkg:
//   - seg_t struct {freq[31:0], cycles[15:0], gap[15:0]}
//   - seq_state_e enum {IDLE, LOAD, RUN, GAP, NEXT, DONE}
//   - ARM_CLKS default constant
// - Sub-module wave_seg_table:
//   - DEPTH x seg_t register file, one sync write port, one async read port, reset-cleared.
// - The FSM, arm counter and gap counter stay in this module.
// TESTING
// - Behavioural model of the triangle generator (ofs_kill semantics incl. stale flag) in the bench.
// - Load 2 segments {freq=1000, cycles=3, gap=10}, {freq=2000, cycles=2, gap=0}; start.
//   - Expect: gen_run high twice; 10-clk gap with run low; freq 1000 then 2000; one done pulse; busy low after.
// - num_segments=0, start -> busy stays 0, gen_run stays 0, no done.
// - Segment cycles=0, start, wait 5000 clks -> run still 1; then stop -> next edge IDLE, run 0, no done.
// - Simultaneous start+stop in IDLE -> stays IDLE. start pulse during RUN -> ignored, seg_idx unchanged.
// - Assert rst_n low mid-GAP -> outputs 0 immediately. Table reads 0 after release.
// - WAVE_SEQ_LOOP_EN, loop=1, 2 segments -> seg_idx sequence 0,1,0,1; done pulses at each wrap.

Source files
------------

// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared types and constants for the burst sequencer.
//   seg_t            : one segment-table entry {freq, cycles, gap}
//   seq_state_e      : sequencer FSM states
//   ARM_CLKS_DEFAULT : default number of clocks to ignore the generator's
//                      active flag after run rises
// ---------------------------------------------------------------------------
package wave_pkg;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] cycles;
        logic [15:0] gap;
    } seg_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        GAP,
        NEXT,
        DONE
    } seq_state_e;

    localparam int ARM_CLKS_DEFAULT = 2;

endpackage

// File: rtl/wave_seg_table.sv
// ---------------------------------------------------------------------------
// wave_seg_table
// DEPTH x seg_t register file. It has one synchronous write port and one
// asynchronous read port. The async reset clears every entry to zero.
// A read of the entry being written in the same clock returns the old
// contents.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write index
//   wr_data_i  in   entry to write
//   rd_addr_i  in   read index
//   rd_data_o  out  entry at rd_addr_i (combinational)
// ---------------------------------------------------------------------------
module wave_seg_table
    import wave_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  seg_t                     wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output seg_t                     rd_data_o
);

    seg_t table_q [DEPTH];

    // Storage array: cleared by reset, one entry written per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            table_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = table_q[rd_addr_i];

endmodule

// File: rtl/wave_burst_sequencer.sv
// ---------------------------------------------------------------------------
// wave_burst_sequencer
// Plays a programmed list of triangle bursts on one DDS waveform generator.
// Each table entry {freq, cycles, gap} becomes one burst. The generator's
// active flag falling marks the end of a burst. After the burst come `gap`
// idle clocks with run low, and then the next entry is loaded.
//
// Optional feature macro: WAVE_SEQ_LOOP_EN
//   When defined, this adds the `loop` input. With loop=1 the list wraps
//   from the last entry back to entry 0, and done pulses once per pass.
//   Only stop ends playback in that case.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_en/wr_addr/wr_freq/wr_cycles/wr_gap   segment-table write port
//   num_segments        number of entries to play (clamped to DEPTH)
//   start, stop         1-clk control pulses (stop wins)
//   loop                (WAVE_SEQ_LOOP_EN only) repeat the list
//   gen_active          generator active flag (1 = burst running)
//   gen_freq/gen_cycles/gen_run   registered generator controls
//   busy                state != IDLE
//   seg_idx             entry currently loaded
//   done                1-clk pulse at list completion
// ---------------------------------------------------------------------------
module wave_burst_sequencer
    import wave_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ARM_CLKS = ARM_CLKS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_freq,
    input  logic [15:0]              wr_cycles,
    input  logic [15:0]              wr_gap,
    input  logic [$clog2(DEPTH):0]   num_segments,
    input  logic                     start,
    input  logic                     stop,
`ifdef WAVE_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    input  logic                     gen_active,
    output logic [31:0]              gen_freq,
    output logic [15:0]              gen_cycles,
    output logic                     gen_run,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] seg_idx,
    output logic                     done
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W   = DEPTH[AW:0];
    localparam logic [15:0] ARM_LIMIT = ARM_CLKS[15:0];

    seq_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   armCount_q, armCount_d;
    logic [15:0]   gapCount_q, gapCount_d;
    logic [15:0]   gap_q;
    logic [31:0]   genFreq_q;
    logic [15:0]   genCycles_q;
    logic          genRun_q, genRun_d;
    logic          done_q, done_d;
    logic          loadSeg;
    logic          loopEn;
    logic          armed;
    logic          isLast;
    logic [AW:0]   numClamped;
    logic [AW:0]   idxPlusOne;
    seg_t          wrSeg;
    seg_t          rdSeg;

`ifdef WAVE_SEQ_LOOP_EN
    assign loopEn = loop;
`else
    assign loopEn = 1'b0;
`endif

    assign wrSeg = '{freq: wr_freq, cycles: wr_cycles, gap: wr_gap};

    wave_seg_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wrSeg),
        .rd_addr_i (idx_q),
        .rd_data_o (rdSeg)
    );

    // An oversized count plays the full table. A count of zero (possible
    // if the host changes it mid-play) makes the current entry the last one.
    assign numClamped = (num_segments > DEPTH_W) ? DEPTH_W : num_segments;
    assign idxPlusOne = {1'b0, idx_q} + (AW + 1)'(1);
    assign isLast     = (idxPlusOne >= numClamped);

    // Just after run rises, the generator's active flag can still show the
    // previous burst's value. It is trusted only after ARM_CLKS clocks of run.
    assign armed = (armCount_q == ARM_LIMIT);

    // Next-state logic. stop overrides every state, including a start in the same clock.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        armCount_d = armCount_q;
        gapCount_d = gapCount_q;
        loadSeg    = 1'b0;
        done_d     = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (num_segments != '0)) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end
                end
                LOAD: begin
                    loadSeg    = 1'b1;
                    armCount_d = '0;
                    state_d    = RUN;
                end
                RUN: begin
                    if (genRun_q && !armed) begin
                        armCount_d = armCount_q + 16'd1;
                    end else if (genRun_q && armed && !gen_active) begin
                        if (gap_q != 16'd0) begin
                            gapCount_d = 16'd1;
                            state_d    = GAP;
                        end else begin
                            state_d = NEXT;
                        end
                    end
                end
                GAP: begin
                    // The count runs from 1 up to gap, so it never wraps, even for 16'hFFFF.
                    if (gapCount_q == gap_q) begin
                        state_d = NEXT;
                    end else begin
                        gapCount_d = gapCount_q + 16'd1;
                    end
                end
                NEXT: begin
                    if (isLast) begin
                        done_d = 1'b1;
                        if (loopEn) begin
                            idx_d   = '0;
                            state_d = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = LOAD;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Run is high only while the FSM stays in RUN. It rises one clock after
    // RUN is entered, so the generator sees run low for at least the LOAD
    // clock and the clock after it.
    assign genRun_d = (state_q == RUN) && (state_d == RUN);

    // State and datapath registers. gen_freq/gen_cycles change only in LOAD.
    // They hold their values through stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            armCount_q  <= '0;
            gapCount_q  <= '0;
            gap_q       <= '0;
            genFreq_q   <= '0;
            genCycles_q <= '0;
            genRun_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            armCount_q <= armCount_d;
            gapCount_q <= gapCount_d;
            genRun_q   <= genRun_d;
            done_q     <= done_d;
            if (loadSeg) begin
                genFreq_q   <= rdSeg.freq;
                genCycles_q <= rdSeg.cycles;
                gap_q       <= rdSeg.gap;
            end
        end
    end

    assign gen_freq   = genFreq_q;
    assign gen_cycles = genCycles_q;
    assign gen_run    = genRun_q;
    assign busy       = (state_q != IDLE);
    assign seg_idx    = idx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_wave_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wave_burst_sequencer
// Self-checking bench for wave_burst_sequencer. It contains a behavioural
// triangle generator whose active flag lags run by one clock (stale flag).
// Each expected burst {freq, cycles, idx, latency} is queued when stimulus
// is driven. The entry is popped and compared when gen_run rises.
// Define WAVE_SEQ_LOOP_EN to also exercise the loop feature.
// ---------------------------------------------------------------------------
module tb_wave_burst_sequencer;

    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int PERIOD = 4;

    typedef struct {
        logic [31:0] freq;
        logic [15:0] cycles;
        logic [AW-1:0] idx;
        int          delay;
    } expEntry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_freq;
    logic [15:0]   wr_cycles;
    logic [15:0]   wr_gap;
    logic [AW:0]   num_segments;
    logic          start;
    logic          stop;
`ifdef WAVE_SEQ_LOOP_EN
    logic          loop;
`endif
    logic          gen_active;
    logic [31:0]   gen_freq;
    logic [15:0]   gen_cycles;
    logic          gen_run;
    logic          busy;
    logic [AW-1:0] seg_idx;
    logic          done;

    expEntry_t expQ[$];
    int  vectorsApplied = 0;
    int  miscompares    = 0;
    int  cycleCnt       = 0;
    int  refCycle       = 0;
    int  doneCount      = 0;
    int  riseCount      = 0;
    logic prevRun       = 1'b0;
    logic prevActive    = 1'b0;

    always #5 clk = ~clk;

    wave_burst_sequencer #(
        .DEPTH    (DEPTH),
        .ARM_CLKS (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_freq      (wr_freq),
        .wr_cycles    (wr_cycles),
        .wr_gap       (wr_gap),
        .num_segments (num_segments),
        .start        (start),
        .stop         (stop),
`ifdef WAVE_SEQ_LOOP_EN
        .loop         (loop),
`endif
        .gen_active   (gen_active),
        .gen_freq     (gen_freq),
        .gen_cycles   (gen_cycles),
        .gen_run      (gen_run),
        .busy         (busy),
        .seg_idx      (seg_idx),
        .done         (done)
    );

    // Generator model: run low clears the phase and the elapsed-cycle count.
    // The active flag follows run one clock late and drops after `cycles`
    // waveform periods (never drops when cycles is 0).
    logic genAct;
    int   phase;
    int   elapsed;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            genAct  <= 1'b0;
            phase   <= 0;
            elapsed <= 0;
        end else if (!gen_run) begin
            genAct  <= 1'b0;
            phase   <= 0;
            elapsed <= 0;
        end else begin
            genAct <= (gen_cycles == 16'd0) || (elapsed < int'(gen_cycles));
            if (phase == PERIOD - 1) begin
                phase   <= 0;
                elapsed <= elapsed + 1;
            end else begin
                phase <= phase + 1;
            end
        end
    end
    assign gen_active = genAct;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: each run rise consumes one queued burst. When the active
    // flag falls during run, the next clock edge is the completion edge,
    // which is the reference point for the next burst's latency.
    always @(negedge clk) begin
        expEntry_t e;
        if (rst_n) begin
            if (done) doneCount++;
            if (gen_run && !prevRun) begin
                riseCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_burst", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("burst_freq", 64'(gen_freq), 64'(e.freq));
                    checkOutput("burst_cycles", 64'(gen_cycles), 64'(e.cycles));
                    checkOutput("burst_seg_idx", 64'(seg_idx), 64'(e.idx));
                    checkOutput("burst_latency", 64'(cycleCnt - refCycle), 64'(e.delay));
                end
            end
            if (gen_run && prevActive && !gen_active) refCycle = cycleCnt + 1;
        end
        prevRun    = gen_run;
        prevActive = gen_active;
    end

    task automatic pushExp(input logic [31:0] f, input logic [15:0] c, input int idx, input int d);
        expEntry_t e;
        e.freq   = f;
        e.cycles = c;
        e.idx    = idx[AW-1:0];
        e.delay  = d;
        expQ.push_back(e);
    endtask

    task automatic writeSegment(input int addr, input logic [31:0] f, input logic [15:0] c, input logic [15:0] g);
        @(posedge clk);
        #1;
        wr_en     = 1'b1;
        wr_addr   = addr[AW-1:0];
        wr_freq   = f;
        wr_cycles = c;
        wr_gap    = g;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // One-clock start/stop pulse. The start reference is the edge that samples it.
    task automatic applyStimulus(input logic doStart, input logic doStop);
        @(posedge clk);
        #1;
        start = doStart;
        stop  = doStop;
        if (doStart) refCycle = cycleCnt + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (n >= budget) checkOutput("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int d0;
        int r0;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_freq      = '0;
        wr_cycles    = '0;
        wr_gap       = '0;
        num_segments = '0;
        start        = 1'b0;
        stop         = 1'b0;
`ifdef WAVE_SEQ_LOOP_EN
        loop         = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_gen_run", 64'(gen_run), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_gen_freq", 64'(gen_freq), 64'd0);
        checkOutput("reset_gen_cycles", 64'(gen_cycles), 64'd0);
        checkOutput("reset_seg_idx", 64'(seg_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-segment list: the burst after a gap of 10 rises gap+3 clocks after completion.
        $display("[TB] two-segment playback");
        writeSegment(0, 32'd1000, 16'd3, 16'd10);
        writeSegment(1, 32'd2000, 16'd2, 16'd0);
        num_segments = 4'd2;
        d0 = doneCount;
        r0 = riseCount;
        pushExp(32'd1000, 16'd3, 0, 2);
        pushExp(32'd2000, 16'd2, 1, 13);
        applyStimulus(1'b1, 1'b0);
        waitIdle(600);
        checkOutput("list_done_pulses", 64'(doneCount - d0), 64'd1);
        checkOutput("list_run_rises", 64'(riseCount - r0), 64'd2);
        checkOutput("list_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("list_run_after", 64'(gen_run), 64'd0);
        checkOutput("list_last_freq", 64'(gen_freq), 64'd2000);

        // A start with num_segments = 0 is ignored.
        $display("[TB] empty list start");
        num_segments = '0;
        d0 = doneCount;
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("empty_busy", 64'(busy), 64'd0);
        checkOutput("empty_run", 64'(gen_run), 64'd0);
        checkOutput("empty_done", 64'(doneCount - d0), 64'd0);

        // Simultaneous start and stop while IDLE: stop wins.
        $display("[TB] start+stop in idle");
        num_segments = 4'd2;
        r0 = riseCount;
        applyStimulus(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("startstop_busy", 64'(busy), 64'd0);
        checkOutput("startstop_rises", 64'(riseCount - r0), 64'd0);

        // Endless segment: only stop ends it. A start during RUN is ignored.
        $display("[TB] endless segment and stop");
        writeSegment(0, 32'd3000, 16'd0, 16'd5);
        num_segments = 4'd1;
        d0 = doneCount;
        pushExp(32'd3000, 16'd0, 0, 2);
        applyStimulus(1'b1, 1'b0);
        repeat (5000) @(posedge clk);
        #2;
        checkOutput("endless_run", 64'(gen_run), 64'd1);
        checkOutput("endless_busy", 64'(busy), 64'd1);
        r0 = riseCount;
        applyStimulus(1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("busy_start_idx", 64'(seg_idx), 64'd0);
        checkOutput("busy_start_rises", 64'(riseCount - r0), 64'd0);
        checkOutput("busy_start_run", 64'(gen_run), 64'd1);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        checkOutput("stop_busy", 64'(busy), 64'd0);
        checkOutput("stop_run", 64'(gen_run), 64'd0);
        checkOutput("stop_freq_hold", 64'(gen_freq), 64'd3000);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("stop_no_done", 64'(doneCount - d0), 64'd0);

        // Reset during GAP clears the outputs at once and empties the table.
        $display("[TB] reset mid-gap");
        writeSegment(0, 32'd4000, 16'd2, 16'd200);
        num_segments = 4'd1;
        pushExp(32'd4000, 16'd2, 0, 2);
        applyStimulus(1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        checkOutput("gap_run_low", 64'(gen_run), 64'd0);
        checkOutput("gap_busy", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_run", 64'(gen_run), 64'd0);
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_freq", 64'(gen_freq), 64'd0);
        checkOutput("async_rst_cycles", 64'(gen_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        num_segments = 4'd1;
        pushExp(32'd0, 16'd0, 0, 2);
        applyStimulus(1'b1, 1'b0);
        repeat (300) @(posedge clk);
        #2;
        checkOutput("cleared_table_run", 64'(gen_run), 64'd1);
        checkOutput("cleared_table_freq", 64'(gen_freq), 64'd0);
        applyStimulus(1'b0, 1'b1);
        #2;
        checkOutput("cleared_stop_busy", 64'(busy), 64'd0);

`ifdef WAVE_SEQ_LOOP_EN
        // Loop mode: seg_idx 0,1,0,1 with a done pulse at the wrap.
        begin
            int n = 0;
            $display("[TB] loop playback");
            writeSegment(0, 32'd1100, 16'd2, 16'd0);
            writeSegment(1, 32'd1200, 16'd2, 16'd0);
            num_segments = 4'd2;
            loop = 1'b1;
            d0 = doneCount;
            pushExp(32'd1100, 16'd2, 0, 2);
            pushExp(32'd1200, 16'd2, 1, 3);
            pushExp(32'd1100, 16'd2, 0, 3);
            pushExp(32'd1200, 16'd2, 1, 3);
            applyStimulus(1'b1, 1'b0);
            while (expQ.size() != 0 && n < 400) begin
                @(posedge clk);
                n++;
            end
            if (n >= 400) checkOutput("loop_timeout", 64'd0, 64'd1);
            #2;
            checkOutput("loop_wrap_done", 64'(doneCount - d0), 64'd1);
            applyStimulus(1'b0, 1'b1);
            loop = 1'b0;
            #2;
            checkOutput("loop_stop_busy", 64'(busy), 64'd0);
        end
`endif

        repeat (5) @(posedge clk);
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
